// File: rtl/rvm_shift_seq.sv
// Iterative shift unit: SLL/SRL/SRA, SHIFT_STEP bit positions per RUN cycle.
// result[32] carries the last bit shifted out; valid pulses for one cycle in DONE.
module rvm_shift_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [1:0]  op,
  output logic        ready,
  output logic        valid,
  output logic [32:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

  state_t      state_reg;
  logic [4:0]  count_reg;
  logic [1:0]  op_reg;
  logic [32:0] result_reg;
  logic        valid_reg;

  logic [4:0]  step_k;
  logic [32:0] shift_tmp;
  logic [32:0] shift_next;

  // Only shamt = rhs[4:0] matters; the upper bits are intentionally dropped.
  logic unused_rhs_bits;
  assign unused_rhs_bits = ^rhs[31:5];

  // result_reg is {carry, value}. Right shifts run on {value, guard} so the
  // guard bit catches the last bit out; the layout is swapped back afterwards.
  always_comb begin
    step_k     = (count_reg < STEP_W) ? count_reg : STEP_W;
    shift_tmp  = '0;
    shift_next = result_reg;
    case (op_reg)
      2'b00: shift_next = {1'b0, result_reg[31:0]} << step_k;
      2'b01: begin
        shift_tmp  = {result_reg[31:0], 1'b0} >> step_k;
        shift_next = {shift_tmp[0], shift_tmp[32:1]};
      end
      2'b10: begin
        shift_tmp  = $signed({result_reg[31:0], 1'b0}) >>> step_k;
        shift_next = {shift_tmp[0], shift_tmp[32:1]};
      end
      default: shift_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            op_reg     <= op;
            // Reserved op skips shifting entirely: one RUN pass, then zero.
            count_reg  <= (op == 2'b11) ? 5'd0 : rhs[4:0];
            result_reg <= {1'b0, lhs};
            state_reg  <= RUN;
          end else if (state_reg == DONE) begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (count_reg == 5'd0) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            if (op_reg == 2'b11) result_reg <= '0;
          end else begin
            result_reg <= shift_next;
            count_reg  <= count_reg - step_k;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready  = (state_reg == IDLE) || (state_reg == DONE);
  assign valid  = valid_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_rvm_shift_seq.sv
// Directed bench for rvm_shift_seq: vector table on SHIFT_STEP=1 and 4 instances,
// plus back-to-back and mid-RUN reset sequences.
module tb_rvm_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [31:0] lhs, rhs;
  logic [1:0]  op;
  logic        ready_a, valid_a, ready_b, valid_b;
  logic [32:0] result_a, result_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvm_shift_seq #(.SHIFT_STEP(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .lhs(lhs), .rhs(rhs), .op(op),
    .ready(ready_a), .valid(valid_a), .result(result_a)
  );

  rvm_shift_seq #(.SHIFT_STEP(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .lhs(lhs), .rhs(rhs), .op(op),
    .ready(ready_b), .valid(valid_b), .result(result_b)
  );

  typedef struct {
    logic        sel;      // 0: STEP=1 instance, 1: STEP=4 instance
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [1:0]  op;
    logic [32:0] exp_res;
    int          exp_lat;  // ceil(shamt/STEP)+2, counted from the start edge
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one operation, waits (bounded) for valid and reports latency/result.
  task automatic run_op(input logic sel, input logic [31:0] l, input logic [31:0] r,
                        input logic [1:0] o, output int lat, output logic [32:0] res);
    logic v;
    lat = 0;
    res = 'x;
    lhs = l; rhs = r; op = o;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    lhs = 32'hA5A5_5A5A; rhs = 32'h0000_0013; op = 2'b00;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      v = sel ? valid_b : valid_a;
      if (v) begin
        lat = n + 1;
        res = sel ? result_b : result_a;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [32:0] res;
    int          n_edges;
    logic        seen;

    vecs[0]  = '{1'b0, 32'h0000_0001, 32'd4,  2'b00, 33'h0_0000_0010, 6};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'd31, 2'b10, 33'h0_FFFF_FFFF, 33};
    vecs[2]  = '{1'b0, 32'h8000_0001, 32'h21, 2'b01, 33'h1_4000_0000, 3};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'd1,  2'b00, 33'h1_0000_0000, 3};
    vecs[4]  = '{1'b0, 32'h1234_5678, 32'd0,  2'b10, 33'h0_1234_5678, 2};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'd31, 2'b01, 33'h1_0000_0001, 33};
    vecs[6]  = '{1'b0, 32'h0000_0003, 32'd31, 2'b00, 33'h1_8000_0000, 33};
    vecs[7]  = '{1'b0, 32'hDEAD_BEEF, 32'd5,  2'b11, 33'h0_0000_0000, 2};
    vecs[8]  = '{1'b0, 32'h8000_0010, 32'd4,  2'b10, 33'h0_F800_0001, 6};
    vecs[9]  = '{1'b0, 32'h0000_00F0, 32'd5,  2'b01, 33'h1_0000_0007, 7};
    vecs[10] = '{1'b1, 32'h0000_0001, 32'd7,  2'b00, 33'h0_0000_0080, 4};
    vecs[11] = '{1'b1, 32'hDEAD_BEEF, 32'd9,  2'b11, 33'h0_0000_0000, 2};
    vecs[12] = '{1'b1, 32'h8000_0000, 32'd31, 2'b10, 33'h0_FFFF_FFFF, 10};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    lhs = '0; rhs = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_a", 64'(ready_a), 64'd1);
    check("reset_valid_a", 64'(valid_a), 64'd0);
    check("reset_result_a", 64'(result_a), 64'd0);
    check("reset_ready_b", 64'(ready_b), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sel, vecs[i].lhs, vecs[i].rhs, vecs[i].op, lat, res);
      $display("vec %0d step=%0d op=%0d lhs=%h shamt=%0d -> result=%h latency=%0d",
               i, vecs[i].sel ? 4 : 1, vecs[i].op, vecs[i].lhs, vecs[i].rhs[4:0], res, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse_width", i), 64'(vecs[i].sel ? valid_b : valid_a), 64'd0);
    end

    // Back-to-back: start held high through RUN with changed inputs; the
    // first op must ignore them, the second must be accepted from DONE.
    lhs = 32'h0000_0010; rhs = 32'd2; op = 2'b01;
    start_a = 1'b1;
    @(posedge clk); #1;
    lhs = 32'hC000_0000; rhs = 32'd1; op = 2'b00;
    seen = 1'b0;
    for (int n = 1; n <= 45 && !seen; n++) begin
      @(posedge clk); #1;
      if (valid_a) seen = 1'b1;
      else check("b2b_ready_in_run", 64'(ready_a), 64'd0);
    end
    check("b2b_first_seen", 64'(seen), 64'd1);
    check("b2b_first_result", 64'(result_a), 64'h0_0000_0004);
    @(posedge clk); #1;
    check("b2b_no_idle_ready", 64'(ready_a), 64'd0);
    start_a = 1'b0;
    n_edges = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (valid_a) begin
        n_edges = n;
        break;
      end
    end
    $display("b2b second op result=%h edges=%0d", result_a, n_edges);
    check("b2b_second_edges", 64'(n_edges), 64'd2);
    check("b2b_second_result", 64'(result_a), 64'h1_8000_0000);

    // Reset mid-RUN: operation abandoned, no valid pulse afterwards.
    repeat (2) @(posedge clk);
    #1;
    lhs = 32'h0000_0001; rhs = 32'd20; op = 2'b00;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("mid-run reset: ready=%0d valid=%0d result=%h", ready_a, valid_a, result_a);
    check("midrst_valid", 64'(valid_a), 64'd0);
    check("midrst_result", 64'(result_a), 64'd0);
    check("midrst_ready", 64'(ready_a), 64'd1);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (valid_a) seen = 1'b1;
    end
    check("midrst_no_pulse", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
